gbe_rx_mac_ctrl_stat: RTL and testbench
=======================================

Name: gbe_rx_mac_ctrl_stat

Overview:
Byte-wide GMII receive MAC controller with status and statistics. It checks preamble/SFD, forwards frame bytes (including FCS) to the RX FIFO write side, and checks CRC-32. It classifies each frame by length, error, CRC and overflow, and emits one status word per frame. It also keeps saturating frame counters for the CPU register block. It sits between the GMII receive pins/PCS and the RX packet FIFO.

Parameters:
RX_IFG_SET, 12, minimum gap; the IFG state lasts RX_IFG_SET-4 enabled cycles.
PREAMBLE_MIN, 1, minimum count of 0x55 bytes required before 0xD5.
LEN_W, 16, width of the frame length counter and config lengths.
CNT_W, 32, width of the statistics counters.

Ports:
clk_i  in  1  clock; single clock domain.
rst_i  in  1  asynchronous, active-high reset.
clk_en_i  in  1  clock enable; all state advances only when it is 1.
rx_d_i  in  8  GMII RXD.
rx_dv_i  in  1  GMII RX_DV.
rx_err_i  in  1  GMII RX_ER.
cfg_min_len_i  in  LEN_W  minimum legal length in bytes, FCS included (typically 64).
cfg_max_len_i  in  LEN_W  maximum legal length in bytes (typically 9600).
fifo_data_o  out  8  data byte to the FIFO.
fifo_data_en_o  out  1  write strobe.
fifo_data_end_o  out  1  end-of-frame marker.
fifo_data_err_o  out  1  frame bad, qualifies end.
fifo_full_i  in  1  FIFO full.
stat_valid_o  out  1  one-cycle status pulse per frame.
stat_len_o  out  LEN_W  byte count of the frame.
stat_flags_o  out  6  {preamble_err, rx_err, too_short, too_long, crc_err, overflow}.
cnt_clr_i  in  1  synchronous clear of all counters.
cnt_ok_o  out  CNT_W  good frames.
cnt_err_o  out  CNT_W  bad frames (any flag set).
cnt_crc_o  out  CNT_W  frames with crc_err.

Behaviour:
- Reset: all outputs 0, state IDLE, delay regs 0, counters 0, status regs 0.
- Input pipeline: dv/d/err are registered to d1; d and err are also registered to d2. fifo_data_o = rx_d_d2, so latency is 2 enabled cycles.
- Strobes decode from state. Consumers sample them only on clk_en_i cycles.
- IDLE: dv_d1 && d1==0x55 -> PREAMBLE with pre_cnt=1. Any other byte is ignored.
- PREAMBLE:
  - !dv_d1 -> IFG; status is issued with preamble_err and len 0.
  - err_d2, or a byte that is neither 0x55 nor 0xD5, or 0xD5 with pre_cnt<PREAMBLE_MIN -> PRE_DROP.
  - 0xD5 with pre_cnt>=PREAMBLE_MIN -> SFD.
  - 0x55 -> pre_cnt++, saturating.
- PRE_DROP: when !dv_d1 -> IFG with a preamble_err status pulse. No FIFO strobes are ever issued for a frame aborted before SFD.
- SFD: one cycle. len=0; CRC is initialised. !dv_d1 -> END with rx_err. err_d2 -> DROP. Otherwise -> DATA.
- DATA: fifo_data_en_o=1, CRC is enabled, len++ saturating at all-ones. Priority, highest first:
  1. !dv_d1 -> CHECK.
  2. fifo_full_i -> END with overflow set, then FULL_DROP.
  3. err_d2 -> DROP with rx_err set.
  4. len>cfg_max_len_i -> DROP with too_long set.
- DROP: no writes. When !dv_d1 -> END.
- CHECK: one cycle. crc_err = CRC residue != 0xC704DD7B. too_short = len<cfg_min_len_i. -> END.
- END: one cycle.
  - fifo_data_end_o=1; fifo_data_err_o = OR of all flags.
  - stat_valid_o=1, with stat_len_o and stat_flags_o held from registers until the next frame.
  - Next state is FULL_DROP if overflow, else IFG.
- FULL_DROP: wait for !dv_d1 -> IFG.
- IFG: counter runs to RX_IFG_SET-4, then -> IDLE. Input is ignored.
- Counters:
  - Update on the stat_valid cycle: ok if flags==0, else err; crc additionally if crc_err.
  - Saturate at all-ones.
  - cnt_clr_i wins over a same-cycle increment.
  - Pre-SFD aborts count as err.
- cfg_* inputs are sampled live. They must be static during a frame.
- rst_i mid-frame returns to IDLE immediately. No end strobe is produced. The FIFO owner handles the partial frame.

Decomposition:
- Package gbe_rx_pkg: state enum, flag bit index constants, CRC residue constant 0xC704DD7B, and the status flags struct.
- Sub-module gbe_rx_crc32: byte-wide CRC-32 (poly 0x04C11DB7, reflected). Inputs: init, en, data, clk_en. Output: residue-match.

Test Plan:
- 7×0x55, 0xD5, 64-byte frame with valid FCS, dv low -> 64 en strobes; end=1, err=0; stat len=64, flags=0; cnt_ok=1.
- Same frame with one payload bit flipped -> end with err=1; flags crc_err only; cnt_err=1, cnt_crc=1.
- 60-byte frame with good CRC and cfg_min=64 -> too_short set, err=1. Separately, cfg_max=100 with a 200-byte frame -> 101 writes, then end after dv falls, too_long set.
- rx_err_i pulse at payload byte 20 -> writes stop within 2 cycles; end+err after dv low; rx_err flag set.
- fifo_full_i asserted at byte 30 -> one END cycle with overflow, no further writes until dv low; next frame accepted after the IFG.
- 0x55, 0x33 preamble -> no FIFO strobes; stat pulse with preamble_err and len 0. Then cnt_clr_i together with a stat pulse -> counters read 0.

Source files
------------

// File: rtl/gbe_rx_pkg.sv
// Shared types and constants for the GMII receive MAC controller.
// Holds the FSM state encoding, the status flag layout and the CRC-32 constants.
package gbe_rx_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_PRE_DROP,
      ST_SFD,
      ST_DATA,
      ST_DROP,
      ST_CHECK,
      ST_END,
      ST_FULL_DROP,
      ST_IFG
   } rx_state_t;

   localparam int FLAG_OVERFLOW  = 0;
   localparam int FLAG_CRC       = 1;
   localparam int FLAG_TOO_LONG  = 2;
   localparam int FLAG_TOO_SHORT = 3;
   localparam int FLAG_RX_ERR    = 4;
   localparam int FLAG_PREAMBLE  = 5;

   localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

   typedef struct packed {
      logic preamble_err;
      logic rx_err;
      logic too_short;
      logic too_long;
      logic crc_err;
      logic overflow;
   } stat_flags_t;

   function automatic logic [31:0] bit_rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/gbe_rx_crc32.sv
// Byte-wide reflected CRC-32 over the frame bytes, FCS included.
// match is high when the accumulated register equals the good-frame residue.
module gbe_rx_crc32
   import gbe_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic       init,
   input  logic       en,
   input  logic [7:0] data,
   output logic       match
);

   localparam logic [31:0] POLY_REFL = bit_rev32(CRC_POLY);

   logic [31:0] crc;

   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ POLY_REFL;
         else             c = c >> 1;
      end
      return c;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc <= '1;
      end else if (clk_en) begin
         if (init)    crc <= '1;
         else if (en) crc <= crc_byte(crc, data);
      end
   end

   // The register runs LSB-first; the residue constant is the MSB-first form.
   assign match = (bit_rev32(crc) == CRC_RESIDUE);

endmodule

// File: rtl/gbe_rx_mac_ctrl_stat.sv
// GMII receive MAC: preamble/SFD check, FIFO write side, CRC check, per-frame status
// and saturating frame counters.
module gbe_rx_mac_ctrl_stat
   import gbe_rx_pkg::*;
#(
   parameter int RX_IFG_SET   = 12,
   parameter int PREAMBLE_MIN = 1,
   parameter int LEN_W        = 16,
   parameter int CNT_W        = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clk_en_i,
   input  logic [7:0]       rx_d_i,
   input  logic             rx_dv_i,
   input  logic             rx_err_i,
   input  logic [LEN_W-1:0] cfg_min_len_i,
   input  logic [LEN_W-1:0] cfg_max_len_i,
   output logic [7:0]       fifo_data_o,
   output logic             fifo_data_en_o,
   output logic             fifo_data_end_o,
   output logic             fifo_data_err_o,
   input  logic             fifo_full_i,
   output logic             stat_valid_o,
   output logic [LEN_W-1:0] stat_len_o,
   output logic [5:0]       stat_flags_o,
   input  logic             cnt_clr_i,
   output logic [CNT_W-1:0] cnt_ok_o,
   output logic [CNT_W-1:0] cnt_err_o,
   output logic [CNT_W-1:0] cnt_crc_o
);

   localparam logic [7:0] IFG_LAST = 8'(RX_IFG_SET - 5);
   localparam logic [3:0] PRE_MIN  = 4'(PREAMBLE_MIN);

   rx_state_t        state, state_nxt;
   logic             dv_d1, err_d1, err_d2;
   logic [7:0]       d1, d2;
   logic [3:0]       pre_cnt, pre_cnt_nxt;
   logic [LEN_W-1:0] len_q, len_nxt, len_inc;
   stat_flags_t      flags_q, flags_nxt;
   logic             pre_stat_q, pre_abort;
   logic [7:0]       ifg_cnt;
   logic             crc_match;

   assign len_inc = (&len_q) ? len_q : len_q + 1'b1;

   always_comb begin
      state_nxt   = state;
      pre_cnt_nxt = pre_cnt;
      len_nxt     = len_q;
      flags_nxt   = flags_q;
      pre_abort   = 1'b0;
      case (state)
         ST_IDLE:
            if (dv_d1 && d1 == 8'h55) begin
               state_nxt   = ST_PREAMBLE;
               pre_cnt_nxt = 4'd1;
            end
         ST_PREAMBLE:
            if (!dv_d1)
               pre_abort = 1'b1;
            else if (err_d2 || (d1 != 8'h55 && d1 != 8'hD5) || (d1 == 8'hD5 && pre_cnt < PRE_MIN))
               state_nxt = ST_PRE_DROP;
            else if (d1 == 8'hD5)
               state_nxt = ST_SFD;
            else if (pre_cnt != 4'hF)
               pre_cnt_nxt = pre_cnt + 4'd1;
         ST_PRE_DROP:
            if (!dv_d1) pre_abort = 1'b1;
         ST_SFD: begin
            len_nxt   = '0;
            flags_nxt = '0;
            if (!dv_d1) begin
               state_nxt        = ST_END;
               flags_nxt.rx_err = 1'b1;
            end else if (err_d2) begin
               state_nxt        = ST_DROP;
               flags_nxt.rx_err = 1'b1;
            end else begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            len_nxt = len_inc;
            if (!dv_d1) begin
               state_nxt = ST_CHECK;
            end else if (fifo_full_i) begin
               state_nxt          = ST_END;
               flags_nxt.overflow = 1'b1;
            end else if (err_d2) begin
               state_nxt        = ST_DROP;
               flags_nxt.rx_err = 1'b1;
            end else if (len_inc > cfg_max_len_i) begin
               state_nxt          = ST_DROP;
               flags_nxt.too_long = 1'b1;
            end
         end
         ST_DROP:
            if (!dv_d1) state_nxt = ST_END;
         ST_CHECK: begin
            flags_nxt.crc_err   = !crc_match;
            flags_nxt.too_short = (len_q < cfg_min_len_i);
            state_nxt           = ST_END;
         end
         ST_END:
            state_nxt = flags_q.overflow ? ST_FULL_DROP : ST_IFG;
         ST_FULL_DROP:
            if (!dv_d1) state_nxt = ST_IFG;
         ST_IFG:
            if (ifg_cnt == IFG_LAST) state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
      // A frame lost before SFD still reports once, with no FIFO traffic.
      if (pre_abort) begin
         state_nxt              = ST_IFG;
         len_nxt                = '0;
         flags_nxt              = '0;
         flags_nxt.preamble_err = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         dv_d1      <= 1'b0;
         d1         <= '0;
         d2         <= '0;
         err_d1     <= 1'b0;
         err_d2     <= 1'b0;
         pre_cnt    <= '0;
         len_q      <= '0;
         flags_q    <= '0;
         pre_stat_q <= 1'b0;
         ifg_cnt    <= '0;
      end else if (clk_en_i) begin
         state      <= state_nxt;
         dv_d1      <= rx_dv_i;
         d1         <= rx_d_i;
         d2         <= d1;
         err_d1     <= rx_err_i;
         err_d2     <= err_d1;
         pre_cnt    <= pre_cnt_nxt;
         len_q      <= len_nxt;
         flags_q    <= flags_nxt;
         pre_stat_q <= pre_abort;
         ifg_cnt    <= (state == ST_IFG) ? ifg_cnt + 8'd1 : 8'd0;
      end
   end

   gbe_rx_crc32 u_crc (
      .clk    (clk_i),
      .rst    (rst_i),
      .clk_en (clk_en_i),
      .init   (state == ST_SFD),
      .en     (state == ST_DATA),
      .data   (d2),
      .match  (crc_match)
   );

   assign fifo_data_o     = d2;
   assign fifo_data_en_o  = (state == ST_DATA);
   assign fifo_data_end_o = (state == ST_END);
   assign fifo_data_err_o = (state == ST_END) && (|flags_q);
   assign stat_valid_o    = (state == ST_END) || pre_stat_q;
   assign stat_len_o      = len_q;

   assign stat_flags_o[FLAG_OVERFLOW]  = flags_q.overflow;
   assign stat_flags_o[FLAG_CRC]       = flags_q.crc_err;
   assign stat_flags_o[FLAG_TOO_LONG]  = flags_q.too_long;
   assign stat_flags_o[FLAG_TOO_SHORT] = flags_q.too_short;
   assign stat_flags_o[FLAG_RX_ERR]    = flags_q.rx_err;
   assign stat_flags_o[FLAG_PREAMBLE]  = flags_q.preamble_err;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_ok_o  <= '0;
         cnt_err_o <= '0;
         cnt_crc_o <= '0;
      end else if (clk_en_i) begin
         if (cnt_clr_i) begin
            cnt_ok_o  <= '0;
            cnt_err_o <= '0;
            cnt_crc_o <= '0;
         end else if (stat_valid_o) begin
            if (stat_flags_o == 6'd0) begin
               if (!(&cnt_ok_o)) cnt_ok_o <= cnt_ok_o + 1'b1;
            end else begin
               if (!(&cnt_err_o)) cnt_err_o <= cnt_err_o + 1'b1;
            end
            if (stat_flags_o[FLAG_CRC] && !(&cnt_crc_o)) cnt_crc_o <= cnt_crc_o + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gbe_rx_mac_ctrl_stat.sv
// Directed frames with random payloads against a frame-level reference model
// of the receive MAC (write count, status length/flags, counters).
module tb_gbe_rx_mac_ctrl_stat;

   typedef logic [7:0] byte_q_t [$];

   logic        clk = 1'b0;
   logic        rst, clk_en, rx_dv, rx_err, cnt_clr;
   logic [7:0]  rx_d;
   logic [15:0] cfg_min, cfg_max;
   logic [7:0]  fifo_data;
   logic        fifo_data_en, fifo_data_end, fifo_data_err, fifo_full;
   logic        stat_valid;
   logic [15:0] stat_len;
   logic [5:0]  stat_flags;
   logic [31:0] cnt_ok, cnt_err, cnt_crc;

   int passed = 0, total = 0, failed = 0;
   int full_at = 0, full_base = 0;
   bit en_rand = 0;

   // Monitor-owned records of what the FIFO/status side consumed.
   byte_q_t     wq;
   int          wtot = 0, end_cnt = 0, stat_cnt = 0;
   logic        last_end_err = 1'b0;
   logic [15:0] last_len = '0;
   logic [5:0]  last_flags = '0;

   int exp_ok = 0, exp_err = 0, exp_crc = 0;

   assign fifo_full = (full_at != 0) && ((wtot - full_base) >= full_at);

   always #5 clk = ~clk;

   gbe_rx_mac_ctrl_stat dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .clk_en_i       (clk_en),
      .rx_d_i         (rx_d),
      .rx_dv_i        (rx_dv),
      .rx_err_i       (rx_err),
      .cfg_min_len_i  (cfg_min),
      .cfg_max_len_i  (cfg_max),
      .fifo_data_o    (fifo_data),
      .fifo_data_en_o (fifo_data_en),
      .fifo_data_end_o(fifo_data_end),
      .fifo_data_err_o(fifo_data_err),
      .fifo_full_i    (fifo_full),
      .stat_valid_o   (stat_valid),
      .stat_len_o     (stat_len),
      .stat_flags_o   (stat_flags),
      .cnt_clr_i      (cnt_clr),
      .cnt_ok_o       (cnt_ok),
      .cnt_err_o      (cnt_err),
      .cnt_crc_o      (cnt_crc)
   );

   always @(negedge clk) begin
      if (!rst && clk_en) begin
         if (fifo_data_en) begin
            wq.push_back(fifo_data);
            wtot = wtot + 1;
         end
         if (fifo_data_end) begin
            end_cnt      = end_cnt + 1;
            last_end_err = fifo_data_err;
         end
         if (stat_valid) begin
            stat_cnt   = stat_cnt + 1;
            last_len   = stat_len;
            last_flags = stat_flags;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time budget expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc32(input byte_q_t b, input int n);
      logic [31:0] c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'd0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic byte_q_t mk_frame(input int payload);
      byte_q_t f;
      logic [31:0] fcs;
      for (int i = 0; i < payload; i++) f.push_back(8'($urandom));
      fcs = crc32(f, payload);
      for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
      return f;
   endfunction

   // Walk the frame write by write and report where it terminates and why.
   task automatic model(input byte_q_t f, input int err_idx, input int fa,
                        output int w, output logic [5:0] fl);
      int n = f.size();
      logic [31:0] fcs_rx;
      fl = 6'd0;
      w  = n;
      fcs_rx = {f[n-1], f[n-2], f[n-3], f[n-4]};
      for (int k = 1; k <= n; k++) begin
         w = k;
         if (k == n) begin
            fl[1] = (crc32(f, n - 4) != fcs_rx);
            fl[3] = (n < int'(cfg_min));
            break;
         end else if (fa > 0 && k >= fa) begin
            fl[0] = 1'b1;
            break;
         end else if (err_idx == k - 1) begin
            fl[4] = 1'b1;
            break;
         end else if (k > int'(cfg_max)) begin
            fl[2] = 1'b1;
            break;
         end
      end
   endtask

   task automatic drive(input logic dv, input logic [7:0] d, input logic er);
      logic e;
      rx_dv  = dv;
      rx_d   = d;
      rx_err = er;
      do begin
         e = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         clk_en = e;
         @(posedge clk);
         #1;
      end while (!e);
   endtask

   task automatic chk_counters(input string name);
      chk({name, "_cnt_ok"},  128'(cnt_ok),  128'(exp_ok));
      chk({name, "_cnt_err"}, 128'(cnt_err), 128'(exp_err));
      chk({name, "_cnt_crc"}, 128'(cnt_crc), 128'(exp_crc));
   endtask

   task automatic run_frame(input string name, input byte_q_t f, input int err_idx,
                            input int fa, input bit rnd);
      int b_w = wtot, b_end = end_cnt, b_stat = stat_cnt, w, bad;
      logic [5:0] fl;
      full_base = wtot;
      full_at   = fa;
      en_rand   = rnd;
      repeat (7) drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < f.size(); i++) drive(1'b1, f[i], (i == err_idx));
      repeat (20) drive(1'b0, 8'h00, 1'b0);
      full_at = 0;
      en_rand = 0;
      model(f, err_idx, fa, w, fl);
      if (fl == 6'd0) exp_ok++; else exp_err++;
      if (fl[1]) exp_crc++;
      bad = 0;
      for (int i = 0; i < w && b_w + i < wq.size(); i++)
         if (wq[b_w + i] !== f[i]) bad++;
      chk({name, "_writes"},   128'(wtot - b_w),       128'(w));
      chk({name, "_data"},     128'(bad),              128'(0));
      chk({name, "_ends"},     128'(end_cnt - b_end),  128'(1));
      chk({name, "_end_err"},  128'(last_end_err),     128'(fl != 6'd0));
      chk({name, "_stats"},    128'(stat_cnt - b_stat), 128'(1));
      chk({name, "_len"},      128'(last_len),         128'(w));
      chk({name, "_flags"},    128'(last_flags),       128'(fl));
      chk_counters(name);
   endtask

   task automatic run_pre(input string name, input byte_q_t b, input logic clr);
      int b_w = wtot, b_end = end_cnt, b_stat = stat_cnt;
      cnt_clr = clr;
      for (int i = 0; i < b.size(); i++) drive(1'b1, b[i], 1'b0);
      repeat (20) drive(1'b0, 8'h00, 1'b0);
      cnt_clr = 1'b0;
      if (clr) begin
         exp_ok = 0; exp_err = 0; exp_crc = 0;
      end else begin
         exp_err++;
      end
      chk({name, "_writes"}, 128'(wtot - b_w),        128'(0));
      chk({name, "_ends"},   128'(end_cnt - b_end),   128'(0));
      chk({name, "_stats"},  128'(stat_cnt - b_stat), 128'(1));
      chk({name, "_len"},    128'(last_len),          128'(0));
      chk({name, "_flags"},  128'(last_flags),        128'(6'b100000));
      chk_counters(name);
   endtask

   initial begin
      byte_q_t f1, f2, pre;
      rst     = 1'b1;
      clk_en  = 1'b1;
      rx_dv   = 1'b0;
      rx_err  = 1'b0;
      rx_d    = 8'h55;
      cfg_min = 16'd64;
      cfg_max = 16'd9600;
      cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_strobes", 128'({fifo_data_en, fifo_data_end, fifo_data_err, stat_valid}), 128'(0));
      chk("reset_data",    128'(fifo_data), 128'(0));
      chk("reset_stat",    128'({stat_len, stat_flags}), 128'(0));
      chk("reset_cnt",     128'({cnt_ok, cnt_err, cnt_crc}), 128'(0));
      rst = 1'b0;
      repeat (4) drive(1'b0, 8'h00, 1'b0);

      f1 = mk_frame(60);
      run_frame("good64", f1, -1, 0, 1'b0);

      f2 = f1;
      f2[10] = f2[10] ^ 8'h04;
      run_frame("crcbad", f2, -1, 0, 1'b0);

      run_frame("short60", mk_frame(56), -1, 0, 1'b0);

      cfg_max = 16'd100;
      run_frame("long200", mk_frame(196), -1, 0, 1'b0);
      cfg_max = 16'd9600;

      run_frame("rxerr20", mk_frame(60), 20, 0, 1'b0);

      run_frame("full30", mk_frame(60), -1, 30, 1'b0);

      run_frame("rand_en", mk_frame($urandom_range(60, 120)), -1, 0, 1'b1);

      pre = '{8'h55};
      run_pre("pre_dvlow", pre, 1'b0);

      pre = '{8'h55, 8'h33};
      run_pre("pre_bad_clr", pre, 1'b1);

      run_frame("after_clr", mk_frame($urandom_range(60, 80)), -1, 0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
